ber_test_ctrl: RTL and testbench

Sequencer for one PRBS BER link test, built around prbs_generate and prbs_checker.
- Drives generator enable and error injection, and the checker enable through a matching delay line.
- Waits for checker lock with a timeout, runs a fixed-length measurement window, then drains the pipeline.
- Accumulates words sent, bit errors and lock losses into result registers for software/top-level readout.

---
 rtl/ber_test_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ber_test_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_test_ctrl.sv
// Sequencer for one PRBS BER link test: SYNC (lock wait with timeout), RUN (fixed word
// count with optional error injection), DRAIN (flush checker pipeline). Optional macro BER_EARLY_STOP_EN.
module ber_test_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 32,
  parameter int CHK_DLY = 1,
  parameter int LOCK_TO = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] test_len,
  input  logic [15:0]      inj_period,
  input  logic             lock,
  input  logic             valid,
  input  logic [WIDTH:0]   err_num,
`ifdef BER_EARLY_STOP_EN
  input  logic [CNT_W-1:0] err_limit,
  output logic             early_stop,
`endif
  output logic             gen_en,
  output logic             gen_inj_err,
  output logic             chk_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] words_sent,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      inj_cnt,
  output logic [7:0]       lock_loss
);

  localparam int TMR_W = $clog2(LOCK_TO + 1);
  localparam int DRN_W = $clog2(CHK_DLY + 3);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [DRN_W-1:0]   dcnt;
  logic [CNT_W-1:0]   tlen_q;
  logic [15:0]        per_q;
  logic [15:0]        ph;
  logic               lock_q;
  logic [CHK_DLY-1:0] dly;

  logic [CNT_W:0]     err_sum;
  logic [CNT_W-1:0]   ws_inc;
  logic [15:0]        ph_nxt;
  logic               active;
  logic               early_hit;
  logic               stop;

  assign active  = (state == RUN) || (state == DRAIN);
  assign err_sum = {1'b0, err_cnt} + (CNT_W+1)'(err_num);
  assign ws_inc  = words_sent + CNT_W'(1);
  // ph is the position (minus one) of the word currently enabled within the injection period
  assign ph_nxt  = (ph == per_q - 16'd1) ? 16'd0 : ph + 16'd1;

`ifdef BER_EARLY_STOP_EN
  assign early_hit = (state == RUN) && (err_limit != '0) && (err_cnt >= err_limit);
`else
  assign early_hit = 1'b0;
`endif
  assign stop = abort || early_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      dcnt        <= '0;
      tlen_q      <= '0;
      per_q       <= '0;
      ph          <= '0;
      lock_q      <= 1'b0;
      gen_en      <= 1'b0;
      gen_inj_err <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      words_sent  <= '0;
      err_cnt     <= '0;
      inj_cnt     <= '0;
      lock_loss   <= '0;
`ifdef BER_EARLY_STOP_EN
      early_stop  <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      lock_q <= lock;
      if (active && valid && lock)
        err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      if (active && lock_q && !lock && lock_loss != '1)
        lock_loss <= lock_loss + 8'd1;

      case (state)
        IDLE: begin
          if (start && !abort) begin
            words_sent <= '0;
            err_cnt    <= '0;
            inj_cnt    <= '0;
            lock_loss  <= '0;
            timeout    <= 1'b0;
            timer      <= '0;
            tlen_q     <= test_len;
            gen_en     <= 1'b1;
            busy       <= 1'b1;
            state      <= SYNC;
`ifdef BER_EARLY_STOP_EN
            early_stop <= 1'b0;
`endif
          end
        end

        SYNC: begin
          if (abort) begin
            gen_en      <= 1'b0;
            gen_inj_err <= 1'b0;
            dcnt        <= '0;
            state       <= DRAIN;
          end else if (lock) begin
            // the first RUN word is enabled straight from SYNC, so its inject flag is set here
            state       <= RUN;
            per_q       <= inj_period;
            ph          <= '0;
            gen_en      <= (tlen_q != '0);
            gen_inj_err <= (tlen_q != '0) && (inj_period == 16'd1);
          end else if (timer == TMR_W'(LOCK_TO - 1)) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            gen_en  <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        RUN: begin
          if (stop) begin
            // the word in flight at the stop edge is not counted
            gen_en      <= 1'b0;
            gen_inj_err <= 1'b0;
            dcnt        <= '0;
            state       <= DRAIN;
`ifdef BER_EARLY_STOP_EN
            if (early_hit) early_stop <= 1'b1;
`endif
          end else begin
            if (gen_en) begin
              words_sent <= ws_inc;
              ph         <= ph_nxt;
              if (gen_inj_err && inj_cnt != '1) inj_cnt <= inj_cnt + 16'd1;
            end
            if (!gen_en || ws_inc >= tlen_q) begin
              gen_en      <= 1'b0;
              gen_inj_err <= 1'b0;
              dcnt        <= '0;
              state       <= DRAIN;
            end else begin
              gen_inj_err <= (per_q != 16'd0) && (ph_nxt == per_q - 16'd1);
            end
          end
        end

        DRAIN: begin
          if (dcnt == DRN_W'(CHK_DLY + 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dcnt <= dcnt + DRN_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // gen_en to chk_en matching delay line
  always_ff @(posedge clk) begin
    if (!reset) begin
      dly <= '0;
    end else begin
      dly[0] <= gen_en;
      for (int i = 1; i < CHK_DLY; i++) dly[i] <= dly[i-1];
    end
  end

  assign chk_en = dly[CHK_DLY-1];

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Directed bench for ber_test_ctrl; a second instance with 8-bit counters exercises
// err_cnt saturation. Early-stop steps compile in when BER_EARLY_STOP_EN is defined.
module tb_ber_test_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, abort = 1'b0, lock = 1'b0, valid = 1'b0;
  logic [CNT_W-1:0] test_len = '0;
  logic [15:0]      inj_period = '0;
  logic [WIDTH:0]   err_num = '0;

  logic gen_en, gen_inj_err, chk_en, busy, done, timeout;
  logic [CNT_W-1:0] words_sent, err_cnt;
  logic [15:0] inj_cnt;
  logic [7:0]  lock_loss;

  logic s_gen_en, s_gen_inj_err, s_chk_en, s_busy, s_done, s_timeout;
  logic [7:0]  s_words_sent, s_err_cnt;
  logic [15:0] s_inj_cnt;
  logic [7:0]  s_lock_loss;
  logic [7:0]  s_test_len;
  assign s_test_len = test_len[7:0];

`ifdef BER_EARLY_STOP_EN
  logic [CNT_W-1:0] err_limit = '0;
  logic [7:0]       s_err_limit = '0;
  logic             early_stop, s_early_stop;
`endif

  int n_chk = 0, n_fail = 0;

  ber_test_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .CHK_DLY(1), .LOCK_TO(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .test_len(test_len),
    .inj_period(inj_period), .lock(lock), .valid(valid), .err_num(err_num),
`ifdef BER_EARLY_STOP_EN
    .err_limit(err_limit), .early_stop(early_stop),
`endif
    .gen_en(gen_en), .gen_inj_err(gen_inj_err), .chk_en(chk_en), .busy(busy), .done(done),
    .timeout(timeout), .words_sent(words_sent), .err_cnt(err_cnt), .inj_cnt(inj_cnt),
    .lock_loss(lock_loss)
  );

  ber_test_ctrl #(.WIDTH(WIDTH), .CNT_W(8), .CHK_DLY(1), .LOCK_TO(1024)) dut8 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .test_len(s_test_len),
    .inj_period(inj_period), .lock(lock), .valid(valid), .err_num(err_num),
`ifdef BER_EARLY_STOP_EN
    .err_limit(s_err_limit), .early_stop(s_early_stop),
`endif
    .gen_en(s_gen_en), .gen_inj_err(s_gen_inj_err), .chk_en(s_chk_en), .busy(s_busy),
    .done(s_done), .timeout(s_timeout), .words_sent(s_words_sent), .err_cnt(s_err_cnt),
    .inj_cnt(s_inj_cnt), .lock_loss(s_lock_loss)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Runs until done, counting enabled words and injections; echo mimics a checker that
  // reports one bit error on every injected word.
  task automatic wait_done(input int budget, input int per, input bit echo,
                           output int cyc, output int n_gen, output int n_inj, output int inj_bad);
    cyc = 0; n_gen = 0; n_inj = 0; inj_bad = 0;
    while (cyc < budget) begin
      if (gen_en) n_gen++;
      if (gen_inj_err) begin
        n_inj++;
        if (per == 0 || !gen_en || ((int'(words_sent) + 1) % per) != 0) inj_bad++;
      end
      if (echo) begin
        valid   = gen_inj_err;
        err_num = 9'd1;
      end
      step(1);
      cyc++;
      if (done) break;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    int cyc, n_gen, n_inj, inj_bad, k;

    // reset state
    step(2);
    check("rst_gen_en", gen_en, 0);
    check("rst_busy", busy, 0);
    check("rst_chk_en", chk_en, 0);
    check("rst_words", words_sent, 0);
    reset = 1'b1;
    step(1);

    // clean link: lock rises three cycles into SYNC
    test_len = 100; inj_period = 0; valid = 1'b1; err_num = 0; lock = 1'b0;
    pulse_start();
    check("clean_busy", busy, 1);
    check("clean_gen_en_sync", gen_en, 1);
    step(3);
    lock = 1'b1;
    wait_done(400, 0, 1'b0, cyc, n_gen, n_inj, inj_bad);
    check("clean_latency", cyc, 104);
    check("clean_gen_cycles", n_gen, 101);
    check("clean_words", words_sent, 100);
    check("clean_err", err_cnt, 0);
    check("clean_inj", inj_cnt, 0);
    check("clean_busy_after", busy, 0);
    step(1);
    check("clean_done_once", done, 0);
    valid = 1'b0;

    // injection every 25th word, checker echoes one error per injected word
    test_len = 200; inj_period = 25;
    pulse_start();
    wait_done(400, 25, 1'b1, cyc, n_gen, n_inj, inj_bad);
    valid = 1'b0;
    check("inj_latency", cyc, 204);
    check("inj_gen_cycles", n_gen, 201);
    check("inj_pulses", n_inj, 8);
    check("inj_placement", inj_bad, 0);
    check("inj_cnt", inj_cnt, 8);
    check("inj_err_cnt", err_cnt, 8);
    check("inj_words", words_sent, 200);

    // test_len = 0: RUN ends at once
    test_len = 0; inj_period = 0;
    pulse_start();
    wait_done(50, 0, 1'b0, cyc, n_gen, n_inj, inj_bad);
    check("zero_latency", cyc, 5);
    check("zero_gen_cycles", n_gen, 1);
    check("zero_words", words_sent, 0);

    // lock timeout
    lock = 1'b0; test_len = 100;
    pulse_start();
    wait_done(1100, 0, 1'b0, cyc, n_gen, n_inj, inj_bad);
    check("to_latency", cyc, 1024);
    check("to_gen_cycles", n_gen, 1024);
    check("to_timeout", timeout, 1);
    check("to_gen_en", gen_en, 0);
    check("to_words", words_sent, 0);
    step(2);
    check("to_sticky", timeout, 1);

    // abort at words_sent = 37, with an ignored start mid-RUN
    lock = 1'b1; test_len = 100;
    pulse_start();
    check("abort_to_cleared", timeout, 0);
    k = 0;
    while (words_sent != 20 && k < 100) begin step(1); k++; end
    pulse_start();
    check("busy_start_ignored", words_sent, 21);
    check("busy_start_busy", busy, 1);
    k = 0;
    while (words_sent != 37 && k < 100) begin step(1); k++; end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_gen_en", gen_en, 0);
    check("abort_chk_en_lag", chk_en, 1);
    check("abort_busy", busy, 1);
    step(1);
    check("abort_chk_en", chk_en, 0);
    wait_done(20, 0, 1'b0, cyc, n_gen, n_inj, inj_bad);
    check("abort_drain_left", cyc, 2);
    check("abort_words", words_sent, 37);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_gen_en", gen_en, 0);
    check("sa_results_hold", words_sent, 37);

    // lock loss: two 2-cycle drops in RUN, valid errors during drops ignored
    test_len = 30; valid = 1'b1; err_num = 1; lock = 1'b1;
    pulse_start();
    step(6);
    lock = 1'b0; step(2); lock = 1'b1;
    step(5);
    lock = 1'b0; step(2); lock = 1'b1;
    wait_done(100, 0, 1'b0, cyc, n_gen, n_inj, inj_bad);
    valid = 1'b0;
    check("ll_count", lock_loss, 2);
    check("ll_err_cnt", err_cnt, 29);
    check("ll_words", words_sent, 30);

    // saturation: 43 accumulating cycles x 8 errors overflows 8-bit counters
    test_len = 40; valid = 1'b1; err_num = 8;
    pulse_start();
    wait_done(100, 0, 1'b0, cyc, n_gen, n_inj, inj_bad);
    valid = 1'b0;
    check("sat_wide", err_cnt, 344);
    check("sat_narrow", s_err_cnt, 8'hFF);
    check("sat_narrow_words", s_words_sent, 40);

    // reset mid-RUN
    test_len = 100; inj_period = 3;
    pulse_start();
    step(10);
    reset = 1'b0;
    step(1);
    check("mr_gen_en", gen_en, 0);
    check("mr_inj", gen_inj_err, 0);
    check("mr_chk_en", chk_en, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_words", words_sent, 0);
    check("mr_inj_cnt", inj_cnt, 0);
    check("mr_err", err_cnt, 0);
    reset = 1'b1;
    step(3);
    check("mr_no_done", done, 0);
    check("mr_idle", busy, 0);

`ifdef BER_EARLY_STOP_EN
    // early stop: limit 5, two errors per word -> stop after third word
    err_limit = 5; s_err_limit = 5;
    test_len = 100; inj_period = 0; valid = 1'b1; err_num = 2;
    pulse_start();
    wait_done(100, 0, 1'b0, cyc, n_gen, n_inj, inj_bad);
    valid = 1'b0;
    check("es_words", words_sent, 3);
    check("es_flag", early_stop, 1);
    check("es_gen_en", gen_en, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
